// File: rtl/bank_sched_pkg.sv
// Shared definitions for the bank read scheduler: bank geometry, the
// scheduler state encoding and small address-decode helpers.
package bank_sched_pkg;

    localparam int NBANK  = 4;
    localparam int BANK_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } sched_state_t;

    // Bank index lives in the two least significant address bits.
    function automatic logic [BANK_W-1:0] bank_of(input logic [BANK_W-1:0] addr_lo);
        return addr_lo;
    endfunction

    // One-hot bank enable for a bank index.
    function automatic logic [NBANK-1:0] bank_enable(input logic [BANK_W-1:0] bank);
        logic [NBANK-1:0] en;
        case (bank)
            2'd0:    en = 4'b0001;
            2'd1:    en = 4'b0010;
            2'd2:    en = 4'b0100;
            2'd3:    en = 4'b1000;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/bank_read_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer
// (wrapping), and moves the pointer just past the winner on every grant.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [NREQ-1:0]  i_req,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             hi_found_s, lo_found_s;
    logic [IDX_W-1:0] hi_idx_s, lo_idx_s;

    // Lowest requester at/above the pointer wins; otherwise lowest below it.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            hi_found_s = hi_found_s | (i_req[j] & (j >= int'(ptr_q)));
            hi_idx_s   = (i_req[j] && (j >= int'(ptr_q))) ? IDX_W'(j) : hi_idx_s;
            lo_found_s = lo_found_s | (i_req[j] & (j < int'(ptr_q)));
            lo_idx_s   = (i_req[j] && (j < int'(ptr_q))) ? IDX_W'(j) : lo_idx_s;
        end
        o_idx   = hi_found_s ? hi_idx_s : lo_idx_s;
        o_valid = i_en & (hi_found_s | lo_found_s);
        o_gnt   = '0;
        if (o_valid) begin
            o_gnt[o_idx] = 1'b1;
            ptr_d        = (o_idx == IDX_W'(NREQ - 1)) ? '0 : o_idx + IDX_W'(1);
        end else begin
            ptr_d        = ptr_q;
        end
    end

    // Pointer register, cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bank_read_scheduler.sv
// Round-robin command scheduler for a 4-bank memory shared by NREQ
// requesters. Issues one registered bank command per cycle, tracks reads
// through a LATENCY-deep tag pipeline and routes returned data back.
// Optional build macro BANK_SCHED_STATS_EN adds saturating per-requester
// grant counters on o_gnt_cnt.
module bank_read_scheduler
    import bank_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ-1:0]      i_we,
    input  logic [NREQ*ADDR_W-1:0] i_addr,
    input  logic [NREQ*DATA_W-1:0] i_wdata,
    input  logic                 i_flush,
    output logic [NREQ-1:0]      o_gnt,
    output logic [NBANK-1:0]     o_mem_en,
    output logic                 o_mem_we,
    output logic [ADDR_W-3:0]    o_mem_addr,
    output logic [DATA_W-1:0]    o_mem_wdata,
    output logic [BANK_W-1:0]    o_sel,
    input  logic [DATA_W-1:0]    i_rdata,
    output logic [NREQ-1:0]      o_rvalid,
    output logic [DATA_W-1:0]    o_rdata,
    output logic                 o_busy
`ifdef BANK_SCHED_STATS_EN
    ,
    output logic [NREQ*16-1:0]   o_gnt_cnt
`endif
);

    localparam int IDX_W = $clog2(NREQ);

    sched_state_t state_q, state_d;

    logic             grant_en_s;
    logic [NREQ-1:0]  gnt_s;
    logic [IDX_W-1:0] gnt_idx_s;
    logic             gnt_any_s;

    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_we_s;
    logic [BANK_W-1:0] sel_bank_s;

    logic [NBANK-1:0]  mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BANK_W-1:0] sel_q, sel_d;
    logic              iss_rd_q, iss_rd_d;
    logic [IDX_W-1:0]  iss_id_q, iss_id_d;

    logic [LATENCY-1:0] pipe_v_q;
    logic [IDX_W-1:0]   pipe_id_q [LATENCY];

    logic [NREQ-1:0]   rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              pipe_empty_s;

    // Grants are blocked in reset, while flushing and while draining.
    always_comb begin
        if (i_rst || i_flush || (state_q == DRAIN)) begin
            grant_en_s = 1'b0;
        end else begin
            grant_en_s = 1'b1;
        end
    end

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (grant_en_s),
        .i_req   (i_req),
        .o_gnt   (gnt_s),
        .o_idx   (gnt_idx_s),
        .o_valid (gnt_any_s)
    );

    // Select the winning requester's command fields.
    always_comb begin
        sel_addr_s  = i_addr[gnt_idx_s*ADDR_W +: ADDR_W];
        sel_wdata_s = i_wdata[gnt_idx_s*DATA_W +: DATA_W];
        sel_we_s    = i_we[gnt_idx_s];
        sel_bank_s  = bank_of(sel_addr_s[BANK_W-1:0]);
    end

    // Next values of the issue-stage registers; idle cycles issue nothing.
    always_comb begin
        mem_en_d    = '0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        sel_d       = '0;
        iss_rd_d    = 1'b0;
        iss_id_d    = '0;
        if (gnt_any_s) begin
            mem_en_d    = bank_enable(sel_bank_s);
            mem_we_d    = sel_we_s;
            mem_addr_d  = sel_addr_s[ADDR_W-1:BANK_W];
            mem_wdata_d = sel_wdata_s;
            sel_d       = sel_bank_s;
            iss_rd_d    = ~sel_we_s;
            iss_id_d    = gnt_idx_s;
        end else begin
            mem_en_d    = '0;
        end
    end

    // Nothing in flight once the issue stage and every tag stage are empty.
    always_comb begin
        if (iss_rd_q || (pipe_v_q != '0)) begin
            pipe_empty_s = 1'b0;
        end else begin
            pipe_empty_s = 1'b1;
        end
    end

    // Scheduler next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_flush) begin
                    state_d = DRAIN;
                end else if (i_req != '0) begin
                    state_d = ACTIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (i_flush) begin
                    state_d = DRAIN;
                end else if ((i_req == '0) && pipe_empty_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACTIVE;
                end
            end
            DRAIN: begin
                if (!i_flush && pipe_empty_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read return: the oldest tag selects the requester, data captured from the mux.
    always_comb begin
        rvalid_d = '0;
        if (pipe_v_q[LATENCY-1]) begin
            rvalid_d[pipe_id_q[LATENCY-1]] = 1'b1;
            rdata_d                        = i_rdata;
        end else begin
            rdata_d                        = rdata_q;
        end
    end

    // All scheduler state; reset drops in-flight reads along with everything else.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            mem_en_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            sel_q       <= '0;
            iss_rd_q    <= 1'b0;
            iss_id_q    <= '0;
            pipe_v_q    <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                pipe_id_q[s] <= '0;
            end
            rvalid_q    <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            sel_q       <= sel_d;
            iss_rd_q    <= iss_rd_d;
            iss_id_q    <= iss_id_d;
            pipe_v_q[0]  <= iss_rd_q;
            pipe_id_q[0] <= iss_id_q;
            for (int s = 1; s < LATENCY; s++) begin
                pipe_v_q[s]  <= pipe_v_q[s-1];
                pipe_id_q[s] <= pipe_id_q[s-1];
            end
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign o_gnt       = gnt_s;
    assign o_mem_en    = mem_en_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_sel       = sel_q;
    assign o_rvalid    = rvalid_q;
    assign o_rdata     = rdata_q;
    assign o_busy      = (state_q != IDLE) || !pipe_empty_s;

`ifdef BANK_SCHED_STATS_EN
    logic [15:0] cnt_q [NREQ];

    // Saturating grant counters, one per requester.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NREQ; k++) begin
                cnt_q[k] <= 16'h0000;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (gnt_s[k] && (cnt_q[k] != 16'hFFFF)) begin
                    cnt_q[k] <= cnt_q[k] + 16'h0001;
                end else begin
                    cnt_q[k] <= cnt_q[k];
                end
            end
        end
    end

    // Pack the counters onto the output bus.
    always_comb begin
        o_gnt_cnt = '0;
        for (int k = 0; k < NREQ; k++) begin
            o_gnt_cnt[k*16 +: 16] = cnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_bank_read_scheduler.sv
// Self-checking bench for bank_read_scheduler: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// cycle-schedule model of grants, bank commands and read returns.
module tb_bank_read_scheduler;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 12;
    localparam int LAT  = 2;
    localparam int RING = 16;
    localparam int M_IDLE = 0, M_ACTIVE = 1, M_DRAIN = 2;

    logic            clk = 1'b0;
    logic            rst, flush;
    logic [NREQ-1:0] req, we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [DW-1:0]   rdata_in;
    logic [NREQ-1:0] o_gnt, o_rvalid;
    logic [3:0]      o_mem_en;
    logic            o_mem_we, o_busy;
    logic [AW-3:0]   o_mem_addr;
    logic [DW-1:0]   o_mem_wdata, o_rdata;
    logic [1:0]      o_sel;
`ifdef BANK_SCHED_STATS_EN
    logic [NREQ*16-1:0] o_gnt_cnt;
`endif

    bank_read_scheduler #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .i_flush(flush), .o_gnt(o_gnt), .o_mem_en(o_mem_en),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_sel(o_sel), .i_rdata(rdata_in), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
        .o_busy(o_busy)
`ifdef BANK_SCHED_STATS_EN
        , .o_gnt_cnt(o_gnt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model state ----------------
    logic [DW-1:0] m_mem   [4][64];
    logic [DW-1:0] emu_mem [4][64];
    logic [3:0]    r_en [RING];
    logic          r_we [RING];
    logic [5:0]    r_ad [RING];
    logic [DW-1:0] r_wd [RING];
    logic [1:0]    r_sel[RING];
    logic [3:0]    r_rv [RING];
    logic [DW-1:0] r_rd [RING];
    logic          e_v  [RING];
    logic [DW-1:0] e_d  [RING];
    int            m_cnt[NREQ];
    int cyc = 0, m_ptr = 0, m_mode = M_IDLE, last_rd = -100, gk, jj, slot, eb, ns;
    logic [DW-1:0] m_last = '0;
    logic [3:0]    eg;
    logic [7:0]    ga;
    bit            inflight, exp_busy, any_req;

    initial begin
        for (int s = 0; s < RING; s++) begin
            r_en[s] = '0; r_we[s] = 1'b0; r_ad[s] = '0; r_wd[s] = '0;
            r_sel[s] = '0; r_rv[s] = '0; r_rd[s] = '0; e_v[s] = 1'b0; e_d[s] = '0;
        end
        for (int k = 0; k < NREQ; k++) m_cnt[k] = 0;
    end

    // Compare process: model prediction vs DUT, then model advance and memory emulation.
    always @(negedge clk) begin
        slot    = cyc % RING;
        any_req = (req != 4'b0000);
        gk = -1;
        if (!rst && !flush && m_mode != M_DRAIN) begin
            for (int i = 0; i < NREQ; i++) begin
                jj = (m_ptr + i) % NREQ;
                if (gk < 0 && req[jj]) gk = jj;
            end
        end
        eg = 4'b0000;
        if (gk >= 0) eg[gk] = 1'b1;
        inflight = (last_rd < cyc) && (cyc - last_rd <= LAT + 1);
        exp_busy = (m_mode != M_IDLE) || inflight;
        if (r_rv[slot] != 4'b0000) m_last = r_rd[slot];

        if (chk_en) begin
            chk("gnt", o_gnt, eg);
            chk("mem_en", o_mem_en, r_en[slot]);
            if (r_en[slot] != 4'b0000) begin
                chk("mem_we", o_mem_we, r_we[slot]);
                chk("mem_addr", o_mem_addr, r_ad[slot]);
                chk("sel", o_sel, r_sel[slot]);
                if (r_we[slot]) chk("mem_wdata", o_mem_wdata, r_wd[slot]);
            end
            chk("rvalid", o_rvalid, r_rv[slot]);
            chk("rdata", o_rdata, m_last);
            chk("busy", o_busy, exp_busy);
`ifdef BANK_SCHED_STATS_EN
            for (int k = 0; k < NREQ; k++) chk("gnt_cnt", o_gnt_cnt[k*16 +: 16], 16'(m_cnt[k]));
`endif
        end
        r_en[slot] = '0; r_we[slot] = 1'b0; r_rv[slot] = '0;

        if (rst) begin
            for (int s = 0; s < RING; s++) begin
                r_en[s] = '0; r_we[s] = 1'b0; r_rv[s] = '0;
            end
            for (int k = 0; k < NREQ; k++) m_cnt[k] = 0;
            m_ptr = 0; m_mode = M_IDLE; m_last = '0; last_rd = -100;
        end else begin
            if (gk >= 0) begin
                ga = addr[gk*AW +: AW];
                ns = (cyc + 1) % RING;
                r_en[ns]  = 4'b0001 << ga[1:0];
                r_we[ns]  = we[gk];
                r_ad[ns]  = ga[7:2];
                r_sel[ns] = ga[1:0];
                r_wd[ns]  = wdata[gk*DW +: DW];
                if (we[gk]) begin
                    m_mem[ga[1:0]][ga[7:2]] = wdata[gk*DW +: DW];
                end else begin
                    r_rv[(cyc + 2 + LAT) % RING] = eg;
                    r_rd[(cyc + 2 + LAT) % RING] = m_mem[ga[1:0]][ga[7:2]];
                    last_rd = cyc;
                end
                m_ptr = (gk + 1) % NREQ;
                if (m_cnt[gk] < 65535) m_cnt[gk]++;
            end
            case (m_mode)
                M_IDLE:   m_mode = flush ? M_DRAIN : (any_req ? M_ACTIVE : M_IDLE);
                M_ACTIVE: m_mode = flush ? M_DRAIN : ((!any_req && !inflight) ? M_IDLE : M_ACTIVE);
                default:  m_mode = (!flush && !inflight) ? M_IDLE : M_DRAIN;
            endcase
        end

        // Memory + output mux emulation driven by the DUT's bank commands.
        if (chk_en && o_mem_en != 4'b0000) begin
            eb = 0;
            for (int b = 0; b < 4; b++) if (o_mem_en[b]) eb = b;
            if (o_mem_we) begin
                emu_mem[eb][o_mem_addr] = o_mem_wdata;
            end else begin
                e_v[(cyc + LAT) % RING] = 1'b1;
                e_d[(cyc + LAT) % RING] = emu_mem[eb][o_mem_addr];
            end
        end
        rdata_in = e_v[slot] ? e_d[slot] : DW'($urandom);
        e_v[slot] = 1'b0;
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [NREQ-1:0] g;
    logic [3:0]      e;

    initial begin
        rst = 1'b1; flush = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; rdata_in = '0;
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 64; w++) begin
                m_mem[b][w]   = DW'(b * 64 + w) ^ 12'h3C5;
                emu_mem[b][w] = DW'(b * 64 + w) ^ 12'h3C5;
            end
        end
        m_mem[1][1] = 12'hABC; emu_mem[1][1] = 12'hABC;
        idle(2);
        rst = 1'b0; chk_en = 1'b1;
        #2;
        chk("rst_mem_en", o_mem_en, 4'b0000);
        chk("rst_rvalid", o_rvalid, 4'b0000);
        chk("rst_busy", o_busy, 1'b0);
        step();

        // Single read of 8'h05 by requester 0.
        req = 4'b0001; we = 4'b0000; addr[7:0] = 8'h05;
        #2 chk("t1_gnt", o_gnt, 4'b0001);
        step(); req = '0;
        #2;
        chk("t1_mem_en", o_mem_en, 4'b0010);
        chk("t1_mem_addr", o_mem_addr, 6'h01);
        chk("t1_sel", o_sel, 2'b01);
        idle(3);
        #2;
        chk("t1_rvalid", o_rvalid, 4'b0001);
        chk("t1_rdata", o_rdata, 12'hABC);
        idle(2);

        // Write then read of 8'h13 by requester 2.
        req = 4'b0100; we = 4'b0100; addr[23:16] = 8'h13; wdata[35:24] = 12'h5A5;
        #2 chk("t2_wgnt", o_gnt, 4'b0100);
        step(); req = '0; we = '0;
        #2;
        chk("t2_mem_we", o_mem_we, 1'b1);
        chk("t2_mem_en", o_mem_en, 4'b1000);
        step();
        req = 4'b0100;
        #2 chk("t2_rgnt", o_gnt, 4'b0100);
        step(); req = '0;
        idle(3);
        #2;
        chk("t2_rvalid", o_rvalid, 4'b0100);
        chk("t2_rdata", o_rdata, 12'h5A5);
        idle(2);

        // All four requesters held for 8 cycles from pointer 0.
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111; we = '0; addr = 32'h91_4E_27_C8;
        for (int i = 0; i < 8; i++) begin
            e = 4'b0001 << (i % 4);
            #2 chk("rr_gnt", o_gnt, e);
            step();
        end
        req = '0;
        idle(6);

        // Flush with two reads in flight.
        req = 4'b0011; addr = 32'h00_00_0A_05;
        step(); req = 4'b0010;
        step(); req = 4'b1000; flush = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2 chk("fl_gnt", o_gnt, 4'b0000);
            if (i == 2) chk("fl_rv0", o_rvalid, 4'b0001);
            if (i == 3) chk("fl_rv1", o_rvalid, 4'b0010);
            step();
        end
        req = '0; flush = 1'b0;
        step();
        #2 chk("fl_busy", o_busy, 1'b0);
        step();

        // Reset two cycles after a read grant drops the read.
        req = 4'b0001; addr[7:0] = 8'h05;
        step(); req = '0;
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        #2;
        chk("mr_mem_en", o_mem_en, 4'b0000);
        chk("mr_rvalid", o_rvalid, 4'b0000);
        chk("mr_rdata", o_rdata, 12'h000);
        chk("mr_busy", o_busy, 1'b0);
        step();
        #2 chk("mr_rvalid2", o_rvalid, 4'b0000);
        step();

        // Randomized traffic; requests held until granted.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req[k] && $urandom_range(0, 99) < 50) begin
                    req[k] = 1'b1;
                    we[k]  = $urandom_range(0, 2) == 0;
                    addr[k*AW +: AW]  = AW'($urandom);
                    wdata[k*DW +: DW] = DW'($urandom);
                end
            end
            flush = $urandom_range(0, 99) < 4;
            rst   = $urandom_range(0, 199) == 0;
            #2 g = o_gnt;
            step();
            req = req & ~g;
        end
        req = '0; flush = 1'b0; rst = 1'b0;
        idle(8);

`ifdef BANK_SCHED_STATS_EN
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0010; we = 4'b0010; addr[15:8] = 8'h22;
        idle(3);
        req = '0;
        step();
        #2 chk("st_cnt3", o_gnt_cnt[31:16], 16'h0003);
        req = 4'b0010;
        idle(65540);
        req = '0;
        step();
        #2 chk("st_sat", o_gnt_cnt[31:16], 16'hFFFF);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bank_read_scheduler.md
Name: bank_read_scheduler

Overview:
- Round-robin scheduler that shares the 4-bank memory between NREQ requesters; one command (read or write) issued per cycle.
- Decodes bank from address bits [1:0] and drives bank enables, word address and the output-mux select.
- Tracks in-flight reads through a LATENCY-deep tag pipeline and returns read data to the originating requester.
- Sits between the requester masters and the multi-bank memory/output-mux datapath.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ADDR_W, 8, request address width; [1:0] = bank, [ADDR_W-1:2] = word
- DATA_W, 12, data width (matches the bank/mux word)
- LATENCY, 2, cycles from bank command to valid mux output (same value as the mux select pipeline)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req  in  NREQ  request per requester; held until granted
- i_we  in  NREQ  1 = write, 0 = read, per requester
- i_addr  in  NREQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
- i_wdata  in  NREQ*DATA_W  packed write data
- i_flush  in  1  stop granting and drain in-flight reads
- o_gnt  out  NREQ  one-hot grant, combinational, same cycle as accept
- o_mem_en  out  4  one-hot bank enable, registered
- o_mem_we  out  1  write strobe, registered
- o_mem_addr  out  ADDR_W-2  word address, registered
- o_mem_wdata  out  DATA_W  write data, registered
- o_sel  out  2  bank select to output mux, registered with o_mem_en
- i_rdata  in  DATA_W  mux output
- o_rvalid  out  NREQ  one-hot read-return strobe, registered
- o_rdata  out  DATA_W  returned read data, registered
- o_busy  out  1  state != IDLE or reads in flight

Behaviour:
- Reset: all outputs 0; RR pointer = 0; tag pipeline valids cleared; state IDLE.
- Reset mid-operation: in-flight reads are dropped; no o_rvalid is produced for them.
- States:
  - IDLE: no request pending.
  - ACTIVE: granting.
  - DRAIN: i_flush seen; no grants until the tag pipeline is empty.
- Transitions:
  - IDLE -> ACTIVE when any i_req and !i_flush.
  - ACTIVE -> IDLE when no i_req and the pipeline is empty.
  - ACTIVE/IDLE -> DRAIN on i_flush.
  - DRAIN -> IDLE when the pipeline is empty and i_flush is low.
  - i_flush held high keeps the block in DRAIN.
- Arbitration:
  - Grant goes to the first requesting index at or after the RR pointer, wrapping at NREQ.
  - After a grant to k, pointer = (k+1) mod NREQ; with no grant, the pointer is unchanged.
  - No grant in DRAIN or in the reset cycle.
- Issue timing:
  - Grant in cycle T -> o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata/o_sel valid in T+1 for exactly one cycle.
  - o_mem_en = 1 << addr[1:0].
- Read return:
  - A read issued at T+1 pushes {valid, requester id} into a LATENCY-stage pipeline.
  - At T+1+LATENCY, i_rdata is captured.
  - o_rvalid[id] = 1 and o_rdata = i_rdata in T+2+LATENCY, i.e. 4 cycles after grant with LATENCY=2.
  - Writes push valid=0 and produce no response.
- Back-to-back: one grant per cycle sustained; different or same banks in consecutive cycles are allowed (no bank-busy stalls).
- o_rdata holds its last value when o_rvalid = 0.
- Simultaneous i_flush and i_req: flush wins; no grant that cycle.

Optional Feature:
- Macro: BANK_SCHED_STATS_EN.
- Defined:
  - Adds output o_gnt_cnt (NREQ*16): saturating per-requester grant counters.
  - Counters clear on i_rst and stop at 16'hFFFF.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package bank_sched_pkg:
  - NBANK = 4, BANK_W = 2.
  - Typedef sched_state_t enum {IDLE, ACTIVE, DRAIN}.
  - Function bank_of(addr).
- Sub-module rr_arbiter (NREQ parameter): one-hot grant plus pointer update.
- Tag pipeline and FSM stay in the top module.

Test Plan:
- Reset, then single read: req0 read addr 8'h05 at T -> o_gnt=0001 at T, o_mem_en=0010, o_mem_addr=6'h01, o_sel=01 at T+1; bench mux returns 12'hABC at T+3 -> o_rvalid=0001, o_rdata=12'hABC at T+4.
- All 4 requesters held high for 8 cycles -> grants 0,1,2,3,0,1,2,3, one per cycle; 8 o_rvalid strobes in the same order, 4 cycles after each grant.
- Write then read, req2: write addr 8'h13 data 12'h5A5 -> o_mem_we=1, o_mem_en=1000, no o_rvalid; read of 8'h13 -> 12'h5A5 returned to requester 2.
- i_flush asserted with 2 reads in flight -> no o_gnt while high; both o_rvalid delivered; o_busy drops after the last; state IDLE.
- i_rst asserted at T+2 after a grant at T -> no o_rvalid ever for that read; all outputs 0 in the next cycle.
- With BANK_SCHED_STATS_EN defined: 3 grants to req1 -> o_gnt_cnt[31:16] = 3; counter saturates at 16'hFFFF under forced long run.
